// File: rtl/seq_det_pkg.sv
// Package: seq_det_pkg
// Shared definitions for the serial sequence detector:
//   - default sequence width, pattern length and pattern value
//   - cnt_w(): width of a counter that must hold 0..n inclusive
//   - state_t: scan controller states IDLE -> SHIFT -> DONE -> IDLE
package seq_det_pkg;

  localparam int SEQ_W_DEF = 10;
  localparam int PAT_W_DEF = 4;
  localparam logic [PAT_W_DEF-1:0] PATTERN_DEF = 4'b1011;

  // Bits needed to represent every value from 0 up to and including n.
  function automatic int cnt_w(input int n);
    return $clog2(n + 1);
  endfunction

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/sequence_detector_pattern_window.sv
// Module: pattern_window
// Sliding window over the last PAT_W serial bits, plus a saturating count of
// how many bits have entered since the last clear.
// Ports:
//   clk       in  1  system clock
//   rst       in  1  synchronous active-high reset
//   clr       in  1  empty the window and restart the fill count
//   shift_en  in  1  accept bit_in this cycle
//   bit_in    in  1  next serial bit (first in time ends up in the MSB)
//   hit       out 1  combinational: accepting bit_in now completes PATTERN
//                    with at least PAT_W bits seen since the clear
module pattern_window
  import seq_det_pkg::*;
#(
  parameter int                 PAT_W   = PAT_W_DEF,
  parameter logic [PAT_W-1:0]   PATTERN = PATTERN_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic shift_en,
  input  logic bit_in,
  output logic hit
);

  localparam int FILL_W = $clog2(PAT_W + 1);

  logic [PAT_W-1:0]  window;
  logic [PAT_W-1:0]  window_nxt;
  logic [FILL_W-1:0] fill;

  always_comb begin
    window_nxt = {window[PAT_W-2:0], bit_in};
  end

  // A zero-filled window could alias a pattern with leading zeros, so a hit
  // also requires the window to hold PAT_W genuine bits after this shift.
  always_comb begin
    hit = shift_en && (fill >= FILL_W'(PAT_W - 1)) && (window_nxt == PATTERN);
  end

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      window <= '0;
      fill   <= '0;
    end else if (shift_en) begin
      window <= window_nxt;
      if (fill != FILL_W'(PAT_W)) begin
        fill <= fill + FILL_W'(1);
      end
    end
  end

endmodule

// File: rtl/sequence_detector.sv
// Module: sequence_detector
// Loads a SEQ_W-bit snapshot on start and scans it MSB-first, one bit per
// clock, counting every (overlapping) occurrence of PATTERN.
// Ports:
//   clk          in   1      system clock
//   rst          in   1      synchronous active-high reset
//   start        in   1      begin a scan (only looked at in IDLE)
//   sequence_in  in   SEQ_W  snapshot to scan, captured on the start edge
//   busy         out  1      scan in progress (SHIFT or DONE)
//   bit_out      out  1      bit consumed at the most recent shift edge
//   detected     out  1      one-cycle pulse, that bit completed PATTERN
//   done         out  1      one-cycle pulse, match_count is final
//   match_count  out  CNT_W  matches in the current/last scan
//   pos_mask     out  SEQ_W  only with SEQDET_POS_MASK_EN: bit SEQ_W-k set
//                            for a match ending at scanned bit k
// Optional feature macro: SEQDET_POS_MASK_EN
// Handshake: start is a level sampled at a clock edge in IDLE; it is ignored
// in every other state and never queued. done/detected are single-cycle
// pulses with no acknowledge.
module sequence_detector
  import seq_det_pkg::*;
#(
  parameter int               SEQ_W   = SEQ_W_DEF,
  parameter int               PAT_W   = PAT_W_DEF,
  parameter logic [PAT_W-1:0] PATTERN = PATTERN_DEF,
  parameter int               CNT_W   = cnt_w(SEQ_W)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [SEQ_W-1:0] sequence_in,
  output logic             busy,
  output logic             bit_out,
  output logic             detected,
  output logic             done,
  output logic [CNT_W-1:0] match_count
`ifdef SEQDET_POS_MASK_EN
  ,
  output logic [SEQ_W-1:0] pos_mask
`endif
);

  state_t           state;
  state_t           state_nxt;
  logic [SEQ_W-1:0] sreg;
  logic [CNT_W-1:0] nbits;

  logic load;
  logic shift_en;
  logic last_bit;
  logic finish;
  logic hit;

  // ---- state register ----
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // ---- next state ----
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = SHIFT;
      SHIFT:   if (last_bit) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // ---- control strobes decoded from state ----
  always_comb begin
    load     = (state == IDLE) && start;
    shift_en = (state == SHIFT);
    // nbits still holds k-1 while bit k is being consumed.
    last_bit = shift_en && (nbits == CNT_W'(SEQ_W - 1));
    finish   = (state == DONE);
  end

  pattern_window #(
    .PAT_W   (PAT_W),
    .PATTERN (PATTERN)
  ) u_window (
    .clk      (clk),
    .rst      (rst),
    .clr      (load),
    .shift_en (shift_en),
    .bit_in   (sreg[SEQ_W-1]),
    .hit      (hit)
  );

  // ---- registered datapath and outputs ----
  always_ff @(posedge clk) begin
    if (rst) begin
      sreg        <= '0;
      nbits       <= '0;
      busy        <= 1'b0;
      bit_out     <= 1'b0;
      detected    <= 1'b0;
      done        <= 1'b0;
      match_count <= '0;
    end else if (load) begin
      sreg        <= sequence_in;
      nbits       <= '0;
      busy        <= 1'b1;
      detected    <= 1'b0;
      done        <= 1'b0;
      match_count <= '0;
    end else if (shift_en) begin
      sreg     <= {sreg[SEQ_W-2:0], 1'b0};
      nbits    <= nbits + CNT_W'(1);
      bit_out  <= sreg[SEQ_W-1];
      detected <= hit;
      done     <= last_bit;
      if (hit) begin
        match_count <= match_count + CNT_W'(1);
      end
    end else if (finish) begin
      busy     <= 1'b0;
      detected <= 1'b0;
      done     <= 1'b0;
    end
  end

`ifdef SEQDET_POS_MASK_EN
  // Scanned bit k (1-based) is consumed while nbits == k-1, so shifting a
  // single MSB right by nbits lands on bit SEQ_W-k.
  localparam logic [SEQ_W-1:0] MSB_ONE = {1'b1, {(SEQ_W-1){1'b0}}};

  always_ff @(posedge clk) begin
    if (rst || load) begin
      pos_mask <= '0;
    end else if (hit) begin
      pos_mask <= pos_mask | (MSB_ONE >> nbits);
    end
  end
`else
  // Match-position mask not built in this configuration.
`endif

endmodule

// File: tb/tb_sequence_detector.sv
module tb_sequence_detector;

  localparam int SEQ_W = 10;
  localparam int PAT_W = 4;
  localparam logic [PAT_W-1:0] PATTERN = 4'b1011;

  // ---- clock / reset ----
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic             start;
  logic [SEQ_W-1:0] sequence_in;
  logic             busy;
  logic             bit_out;
  logic             detected;
  logic             done;
  logic [3:0]       match_count;
`ifdef SEQDET_POS_MASK_EN
  logic [SEQ_W-1:0] pos_mask;
`endif

  sequence_detector dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .sequence_in (sequence_in),
    .busy        (busy),
    .bit_out     (bit_out),
    .detected    (detected),
    .done        (done),
    .match_count (match_count)
`ifdef SEQDET_POS_MASK_EN
    ,
    .pos_mask    (pos_mask)
`endif
  );

  // ---- scoreboard ----
  int n_checks = 0;
  int n_errors = 0;
  logic [3:0]       exp_q[$];   // scan positions k at which a match completes
  int               exp_cnt;
  logic [SEQ_W-1:0] exp_mask;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference model: the PAT_W bits ending at scan position k are simply the
  // top k bits of the snapshot with the oldest ones dropped.
  task automatic build_model(input logic [SEQ_W-1:0] seq);
    logic [SEQ_W-1:0] t;
    exp_q.delete();
    exp_cnt  = 0;
    exp_mask = '0;
    for (int k = PAT_W; k <= SEQ_W; k++) begin
      t = seq >> (SEQ_W - k);
      if (t[PAT_W-1:0] == PATTERN) begin
        exp_q.push_back(4'(k));
        exp_cnt++;
        exp_mask[SEQ_W-k] = 1'b1;
      end
    end
  endtask

  // ---- driver: one full scan, optionally scrambling sequence_in mid-scan ----
  task automatic run_scan(input logic [SEQ_W-1:0] seq, input bit scramble);
    int  cnt;
    bit  exp_det;
    build_model(seq);
    @(negedge clk);
    sequence_in = seq;
    start = 1'b1;
    @(posedge clk); #1;
    chk("e0_busy", busy, 1);
    chk("e0_count", match_count, 0);
    chk("e0_done", done, 0);
    @(negedge clk);
    start = 1'b0;
    cnt = 0;
    for (int k = 1; k <= SEQ_W; k++) begin
      if (scramble) sequence_in = SEQ_W'($urandom);
      @(posedge clk); #1;
      exp_det = (exp_q.size() > 0) && (exp_q[0] == 4'(k));
      if (exp_det) begin
        void'(exp_q.pop_front());
        cnt++;
      end
      chk($sformatf("bit_out_k%0d", k), bit_out, seq[SEQ_W-k]);
      chk($sformatf("detected_k%0d", k), detected, exp_det);
      chk($sformatf("count_k%0d", k), match_count, cnt);
      chk($sformatf("done_k%0d", k), done, (k == SEQ_W));
      chk($sformatf("busy_k%0d", k), busy, 1);
      @(negedge clk);
    end
    chk("hits_consumed", exp_q.size(), 0);
`ifdef SEQDET_POS_MASK_EN
    chk("pos_mask", pos_mask, exp_mask);
`endif
    @(posedge clk); #1;
    chk("idle_done", done, 0);
    chk("idle_busy", busy, 0);
    chk("idle_detected", detected, 0);
    chk("idle_count", match_count, exp_cnt);
  endtask

  initial begin
    bit seen;
    rst = 1'b1;
    start = 1'b0;
    sequence_in = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_bit_out", bit_out, 0);
    chk("rst_detected", detected, 0);
    chk("rst_done", done, 0);
    chk("rst_count", match_count, 0);
    @(negedge clk);
    rst = 1'b0;

    // Directed scans
    run_scan(10'b1011011010, 1'b0);
    chk("t1_count", match_count, 2);
    run_scan(10'b1011011011, 1'b0);
    chk("t2_count", match_count, 3);
    run_scan(10'b1111111111, 1'b0);
    run_scan(10'b0000000000, 1'b0);

    // Idle holds the last result
    run_scan(10'b0101101100, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    chk("hold_count", match_count, exp_cnt);
    chk("hold_busy", busy, 0);

    // Reset mid-scan, sampled at E5
    @(negedge clk);
    sequence_in = 10'b1011011011;
    start = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_bit_out", bit_out, 0);
    chk("midrst_detected", detected, 0);
    chk("midrst_done", done, 0);
    chk("midrst_count", match_count, 0);
    @(negedge clk);
    rst = 1'b0;
    run_scan(10'b1011011011, 1'b0);

    // Start held for 15 edges: one scan, then a re-start on the IDLE edge
    build_model(10'b1011011011);
    @(negedge clk);
    sequence_in = 10'b1011011011;
    start = 1'b1;
    for (int e = 0; e < 15; e++) begin
      @(posedge clk); #1;
      chk($sformatf("held_done_e%0d", e), done, (e == SEQ_W));
      chk($sformatf("held_busy_e%0d", e), busy, (e != SEQ_W + 1));
      @(negedge clk);
    end
    start = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(posedge clk); #1;
      if (done) seen = 1'b1;
    end
    chk("held_second_done", seen, 1);
    chk("held_second_count", match_count, exp_cnt);
    @(posedge clk); #1;

    // sequence_in changing during SHIFT must not matter
    run_scan(10'b1011011010, 1'b1);
    run_scan(10'b1011011011, 1'b1);

    // Random scans
    for (int r = 0; r < 12; r++) begin
      run_scan(SEQ_W'($urandom_range(0, (1 << SEQ_W) - 1)), 1'($urandom_range(0, 1)));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
